// File: rtl/dma_memcpy_if.sv
// Control, status and single-port RAM signals of the memcpy/fill DMA engine.
// The slave modport is the engine; the master modport is the requester plus RAM side.
interface dma_memcpy_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 11
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic [31:0]       fill_data;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_wem;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport slave (
        input  start, mode, src_addr, dst_addr, len, fill_data, abort, ram_dout,
        output busy, done, aborted, ram_addr, ram_en, ram_we, ram_wem, ram_din
    );

    modport master (
        output start, mode, src_addr, dst_addr, len, fill_data, abort, ram_dout,
        input  busy, done, aborted, ram_addr, ram_en, ram_we, ram_wem, ram_din
    );
endinterface

// File: rtl/dma_memcpy.sv
// Word-granular memcpy/fill engine driving one single-port RAM.
// Copy alternates read and write cycles (2 cycles/word); fill writes one word per cycle.
module dma_memcpy #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    dma_memcpy_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StFin} state_e;

    state_e            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [31:0]       fill_word;

    // RAM controls are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            fill_word    <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.aborted  <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_en   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_wem  <= 4'h0;
        end else begin
            bus.done    <= 1'b0;
            bus.ram_en  <= 1'b0;
            bus.ram_we  <= 1'b0;
            bus.ram_wem <= 4'h0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        src_ptr     <= bus.src_addr;
                        dst_ptr     <= bus.dst_addr;
                        remaining   <= bus.len;
                        fill_word   <= bus.fill_data;
                        bus.aborted <= 1'b0;
                        bus.busy    <= 1'b1;
                        if (bus.len == '0) begin
                            state    <= StFin;
                            bus.done <= 1'b1;
                        end else if (!bus.mode) begin
                            state        <= StRd;
                            bus.ram_en   <= 1'b1;
                            bus.ram_addr <= bus.src_addr;
                        end else begin
                            state        <= StFill;
                            bus.ram_en   <= 1'b1;
                            bus.ram_we   <= 1'b1;
                            bus.ram_wem  <= 4'hF;
                            bus.ram_addr <= bus.dst_addr;
                        end
                    end
                end
                StRd: begin
                    if (bus.abort) begin
                        state       <= StFin;
                        bus.done    <= 1'b1;
                        bus.aborted <= 1'b1;
                    end else begin
                        state        <= StWr;
                        bus.ram_en   <= 1'b1;
                        bus.ram_we   <= 1'b1;
                        bus.ram_wem  <= 4'hF;
                        bus.ram_addr <= dst_ptr;
                    end
                end
                StWr: begin
                    src_ptr   <= src_ptr + 1'b1;
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    // Abort wins over the last-word exit so aborted is reported.
                    if (bus.abort || remaining == LEN_W'(1)) begin
                        state    <= StFin;
                        bus.done <= 1'b1;
                        if (bus.abort) bus.aborted <= 1'b1;
                    end else begin
                        state        <= StRd;
                        bus.ram_en   <= 1'b1;
                        bus.ram_addr <= src_ptr + 1'b1;
                    end
                end
                StFill: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (bus.abort || remaining == LEN_W'(1)) begin
                        state    <= StFin;
                        bus.done <= 1'b1;
                        if (bus.abort) bus.aborted <= 1'b1;
                    end else begin
                        bus.ram_en   <= 1'b1;
                        bus.ram_we   <= 1'b1;
                        bus.ram_wem  <= 4'hF;
                        bus.ram_addr <= dst_ptr + 1'b1;
                    end
                end
                StFin: begin
                    state    <= StIdle;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= StIdle;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // Read data only arrives during the write cycle, so it is forwarded combinationally.
    always_comb begin
        bus.ram_din = '0;
        if (state == StWr) begin
            bus.ram_din = bus.ram_dout;
        end else if (state == StFill) begin
            bus.ram_din = fill_word;
        end
    end
endmodule

// File: tb/tb_dma_memcpy.sv
// Randomized bench for dma_memcpy with a behavioural RAM and a word-level reference model.
module tb_dma_memcpy;
    localparam int unsigned AW = 10;
    localparam int unsigned LW = 11;
    localparam int D = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_memcpy_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
    dma_memcpy #(.ADDR_W(AW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0]   ram     [D];
    logic [31:0]   exp_mem [D];
    logic [31:0]   ram_q = '0;
    int            wr_cnt = 0;
    int            en_cnt = 0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = '0;
    int            checks = 0;
    int            failures = 0;
    bit            exp_aborted = 1'b0;

    assign bus.ram_dout = ram_q;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        if (bus.ram_en) begin
            en_cnt <= en_cnt + 1;
            if (bus.ram_we) begin
                wr_cnt <= wr_cnt + 1;
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wem[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end else begin
                ram_q <= ram[bus.ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = AW'(addr);
        bd_data = data;
        exp_mem[addr % D] = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        int diff = 0;
        for (int i = 0; i < D; i++) if (ram[i] !== exp_mem[i]) diff++;
        chk(tag, 64'(diff), 64'd0);
    endtask

    task automatic run_xfer(input logic m, input int src, input int dst, input int ln,
                            input logic [31:0] fd, input int abort_at, input bit second,
                            input string name);
        int dur, exp_done, words, exp_en, done_cyc, done_cnt, busy_err, wr0, en0;
        bit ab;
        dur = (ln == 0) ? 1 : (m ? ln + 1 : 2 * ln + 1);
        ab  = (ln != 0) && abort_at >= 1 && abort_at < dur;
        if (ab) begin
            exp_done = abort_at + 1;
            words    = m ? abort_at : abort_at / 2;
            exp_en   = abort_at;
        end else begin
            exp_done = dur;
            words    = ln;
            exp_en   = m ? ln : 2 * ln;
        end
        chk({name, "_aborted_hold"}, 64'(bus.aborted), 64'(exp_aborted));
        @(negedge clk);
        wr0 = wr_cnt;
        en0 = en_cnt;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.src_addr  = AW'(src);
        bus.dst_addr  = AW'(dst);
        bus.len       = LW'(ln);
        bus.fill_data = fd;
        done_cyc = 0;
        done_cnt = 0;
        busy_err = 0;
        for (int k = 1; k <= dur + 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== (k <= exp_done)) busy_err++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k == 1) chk({name, "_aborted_clr"}, 64'(bus.aborted), 64'd0);
            bus.start = second && exp_done >= 2 && k == 2;
            if (bus.start) begin
                bus.mode      = ~m;
                bus.src_addr  = AW'($urandom);
                bus.dst_addr  = AW'($urandom);
                bus.len       = LW'($urandom_range(1, 9));
                bus.fill_data = $urandom;
            end
            bus.abort = (k == abort_at);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < words; i++)
            exp_mem[(dst + i) % D] = m ? fd : exp_mem[(src + i) % D];
        exp_aborted = ab;
        chk({name, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, "_busy"}, 64'(busy_err), 64'd0);
        chk({name, "_writes"}, 64'(wr_cnt - wr0), 64'(words));
        chk({name, "_enables"}, 64'(en_cnt - en0), 64'(exp_en));
        chk({name, "_aborted"}, 64'(bus.aborted), 64'(ab));
        mem_check({name, "_mem"});
    endtask

    task automatic reset_outputs(input string name);
        chk({name, "_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "_done"}, 64'(bus.done), 64'd0);
        chk({name, "_aborted"}, 64'(bus.aborted), 64'd0);
        chk({name, "_ram_en"}, 64'(bus.ram_en), 64'd0);
        chk({name, "_ram_we"}, 64'(bus.ram_we), 64'd0);
        chk({name, "_ram_wem"}, 64'(bus.ram_wem), 64'd0);
        chk({name, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
        chk({name, "_ram_din"}, 64'(bus.ram_din), 64'd0);
    endtask

    task automatic reset_mid_fill();
        int wr0, done_cnt;
        @(negedge clk);
        wr0 = wr_cnt;
        bus.start     = 1'b1;
        bus.mode      = 1'b1;
        bus.dst_addr  = AW'(10'h200);
        bus.len       = LW'(10);
        bus.fill_data = 32'hCAFEF00D;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        for (int i = 0; i < 2; i++) exp_mem[(10'h200 + i) % D] = 32'hCAFEF00D;
        exp_aborted = 1'b0;
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        chk("midrst_writes", 64'(wr_cnt - wr0), 64'd2);
        mem_check("midrst_mem");
    endtask

    initial begin
        int m, ln, dur, ab;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.len = '0; bus.fill_data = '0; bus.abort = 1'b0;
        #1;
        reset_outputs("rst");
        for (int i = 0; i < D; i++) bd_write(i, $urandom);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) bd_write(10'h010 + i, 32'hA0 + 32'(i));
        run_xfer(1'b0, 10'h010, 10'h100, 4, 32'h0, 0, 1'b0, "copy4");
        run_xfer(1'b1, 10'h000, 10'h3FE, 4, 32'hDEADBEEF, 0, 1'b0, "fillwrap");
        run_xfer(1'b0, 10'h055, 10'h155, 0, 32'h0, 0, 1'b0, "len0");
        run_xfer(1'b0, 10'h080, 10'h180, 8, 32'h0, 6, 1'b0, "abort3");
        run_xfer(1'b0, 10'h300, 10'h3FD, 6, 32'h0, 0, 1'b1, "second");
        run_xfer(1'b0, 10'h020, 10'h022, 6, 32'h0, 0, 1'b0, "overlap");
        run_xfer(1'b1, 10'h000, 10'h040, 3, 32'h12345678, 3, 1'b0, "abortlast");
        reset_mid_fill();

        for (int it = 0; it < 40; it++) begin
            m   = $urandom_range(0, 1);
            ln  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 10);
            dur = (ln == 0) ? 1 : (m != 0 ? ln + 1 : 2 * ln + 1);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, dur) : 0;
            run_xfer(m[0], $urandom_range(0, D - 1), $urandom_range(0, D - 1), ln, $urandom,
                     ab, $urandom_range(0, 3) == 0, $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_memcpy.md
DMA_MEMCPY -- requirements
Module: dma_memcpy

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM word-address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter LEN_W, default 11, meaning transfer-length counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port mode  input  1  sampled with start: 0 = copy, 1 = fill.
REQ-007 SHALL have port src_addr  input  ADDR_W  copy source word address, sampled with start.
REQ-008 SHALL have port dst_addr  input  ADDR_W  destination word address, sampled with start.
REQ-009 SHALL have port len  input  LEN_W  number of words, sampled with start.
REQ-010 SHALL have port fill_data  input  32  fill pattern, sampled with start.
REQ-011 SHALL have port abort  input  1  stop transfer at the next edge.
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port aborted  output  1  sticky: last transfer ended by abort; cleared on accepted start.
REQ-015 SHALL have port ram_addr  output  ADDR_W  RAM port address.
REQ-016 SHALL have port ram_en  output  1  RAM port enable.
REQ-017 SHALL have port ram_we  output  1  RAM port write enable.
REQ-018 SHALL have port ram_wem  output  4  byte write mask, bit i = bits 8i+7:8i.
REQ-019 SHALL have port ram_din  output  32  write data to RAM.
REQ-020 SHALL have port ram_dout  input  32  RAM read data, valid the cycle after an enabled non-write access.

Function
REQ-021 SHALL implement FSM states IDLE, RD, WR, FILL, FIN.
REQ-022 SHALL, in IDLE with start=1: latch inputs, clear aborted, go to FIN if len=0, else RD (mode 0) or FILL (mode 1).
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL, in RD, drive ram_en=1, ram_we=0, ram_addr=current src; next state WR.
REQ-025 SHALL, in WR, drive ram_en=1, ram_we=1, ram_wem=4'hF, ram_addr=current dst, ram_din=ram_dout; then increment src, dst, decrement remaining count.
REQ-026 SHALL leave WR for FIN when remaining count reaches 0, else return to RD; copy throughput is 2 cycles/word.
REQ-027 SHALL, in FILL, drive ram_en=1, ram_we=1, ram_wem=4'hF, ram_addr=current dst, ram_din=latched fill_data, one word per cycle, FIN after the last word.
REQ-028 SHALL wrap src/dst addresses modulo 2^ADDR_W without error.
REQ-029 SHALL, in FIN, assert done=1 for one cycle and return to IDLE.
REQ-030 SHALL assert busy in RD, WR, FILL and FIN; deassert in IDLE.
REQ-031 SHALL drive ram_en=0, ram_we=0, ram_wem=0 in IDLE and FIN.
REQ-032 SHALL, on abort=1 in RD/WR/FILL, complete the current cycle's RAM access, set aborted, go to FIN; abort in IDLE/FIN has no effect.
REQ-033 SHALL give abort priority over the final-word transition to FIN (aborted set even on the last word).
REQ-034 SHALL treat overlapping source/destination as forward sequential copy, no overlap correction.

Reset
REQ-035 SHALL, on rst_n=0 asynchronously: state IDLE, busy=0, done=0, aborted=0, ram_en=0, ram_we=0, ram_wem=0, ram_addr=0, ram_din=0, internal counters 0.
REQ-036 SHALL discard any in-progress transfer when reset asserts mid-operation; no done pulse after release.

Verification
REQ-037 SHALL pass: copy src=0x010 dst=0x100 len=4 over RAM preloaded 0xA0..0xA3 -> words 0x100..0x103 = 0xA0..0xA3, done pulses on cycle 9 after start, busy high cycles 1-9.
REQ-038 SHALL pass: fill dst=0x3FE len=4 fill_data=0xDEADBEEF, ADDR_W=10 -> words 0x3FE,0x3FF,0x000,0x001 written, done at cycle 5.
REQ-039 SHALL pass: start with len=0 -> no RAM enable, done one cycle later, aborted=0.
REQ-040 SHALL pass: copy len=8, abort during 3rd WR -> exactly 3 words written, done next cycle, aborted=1 until next start.
REQ-041 SHALL pass: second start while busy -> ignored, first transfer completes unchanged.
REQ-042 SHALL pass: rst_n low mid-fill -> outputs reset immediately, RAM writes stop, no done.
